// File: rtl/stream_packer_if.sv
// Stream bundle around the packer: narrow beats in, packed words out.
// The environment (upstream source plus downstream FIFO) uses the master
// modport; the packer uses the slave modport.
interface stream_packer_if #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4
);
   // Narrow input beat stream
   logic [IN_WIDTH-1:0]       in_data;
   logic                      in_last;
   logic                      in_valid;
   logic                      in_ready;
   // Packed output word stream
   logic [IN_WIDTH*RATIO-1:0] out_data;
   logic [RATIO-1:0]          out_strb;
   logic                      out_last;
   logic                      out_valid;
   logic                      out_ready;

   modport master (
      output in_data, in_last, in_valid, out_ready,
      input  in_ready, out_data, out_strb, out_last, out_valid
   );

   modport slave (
      input  in_data, in_last, in_valid, out_ready,
      output in_ready, out_data, out_strb, out_last, out_valid
   );
endinterface

// File: rtl/stream_packer.sv
// Packs RATIO narrow beats into one wide word ahead of the CDC FIFO.
// A word closes when full, on a last-flagged beat, or after TIMEOUT idle
// cycles with a partial word pending. The accumulator hands its word to the
// output register in the same cycle a new beat may land in lane 0, so a
// continuous stream runs without bubbles.
module stream_packer #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic           clk_i,
   input  logic           rst_i,
   stream_packer_if.slave bus
);

   localparam int CNT_W = $clog2(RATIO + 1);
   localparam int OUT_W = IN_WIDTH * RATIO;

   // Accumulator state
   logic [CNT_W-1:0] acc_cnt_reg;
   logic             acc_last_reg;
   logic             closed_reg;

   // Output register
   logic [OUT_W-1:0] out_data_reg;
   logic [RATIO-1:0] out_strb_reg;
   logic             out_last_reg;
   logic             out_valid_reg;

   // Word presented to the output register at handover (unfilled lanes zeroed)
   logic [OUT_W-1:0] out_data_next;
   logic [RATIO-1:0] out_strb_next;

   logic             out_free;
   logic             handover;
   logic             in_ready;
   logic             accept;
   logic             timeout_fire;
   logic [CNT_W-1:0] base_cnt;
   logic [CNT_W-1:0] fill_cnt;

   assign out_free = !out_valid_reg | bus.out_ready;
   assign handover = closed_reg & out_free;
   assign in_ready = !closed_reg | handover;
   assign accept   = bus.in_valid & in_ready;

   // On a handover the accumulator is logically empty, so the beat goes to lane 0
   assign base_cnt = handover ? '0 : acc_cnt_reg;
   assign fill_cnt = base_cnt + CNT_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < RATIO; gi++) begin : lane_g
         logic [IN_WIDTH-1:0] lane_reg;

         // Capture the accepted beat into the lane it is addressed to
         always_ff @(posedge clk_i) begin
            if (accept && (base_cnt == CNT_W'(gi))) begin
               lane_reg <= bus.in_data;
            end
         end

         // Lane is valid iff it lies below the fill count: strb = (1<<cnt)-1
         assign out_strb_next[gi] = (CNT_W'(gi) < acc_cnt_reg);
         assign out_data_next[gi*IN_WIDTH +: IN_WIDTH] =
            out_strb_next[gi] ? lane_reg : '0;
      end
   endgenerate

   generate
      if (TIMEOUT > 0) begin : timeout_g
         localparam int TO_W = $clog2(TIMEOUT + 1);
         logic [TO_W-1:0] idle_cnt_reg;
         logic            idle_cycle;

         assign idle_cycle = (acc_cnt_reg != '0) & !closed_reg & !accept;
         // Fires on the idle cycle that brings the counter to TIMEOUT; an
         // accepted beat in that cycle is not idle, so the beat wins.
         assign timeout_fire = idle_cycle & (idle_cnt_reg == TO_W'(TIMEOUT - 1));

         // Idle counter: counts idle cycles with a partial word, saturating
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               idle_cnt_reg <= '0;
            end else if (accept || handover) begin
               idle_cnt_reg <= '0;
            end else if (idle_cycle && (idle_cnt_reg != TO_W'(TIMEOUT))) begin
               idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
            end
         end
      end else begin : no_timeout_g
         assign timeout_fire = 1'b0;
      end
   endgenerate

   // Accumulator control: clear on handover, fill on accept, close on full/last/timeout
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_cnt_reg  <= '0;
         acc_last_reg <= 1'b0;
         closed_reg   <= 1'b0;
      end else begin
         if (handover) begin
            acc_cnt_reg <= '0;
            closed_reg  <= 1'b0;
         end
         if (accept) begin
            acc_cnt_reg  <= fill_cnt;
            closed_reg   <= (fill_cnt == CNT_W'(RATIO)) | bus.in_last;
            acc_last_reg <= bus.in_last;
         end else if (timeout_fire) begin
            closed_reg   <= 1'b1;
            acc_last_reg <= 1'b0;
         end
      end
   end

   // Output register: load on handover, drop valid after a transfer, else hold
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_data_reg  <= '0;
         out_strb_reg  <= '0;
         out_last_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
      end else if (handover) begin
         out_data_reg  <= out_data_next;
         out_strb_reg  <= out_strb_next;
         out_last_reg  <= acc_last_reg;
         out_valid_reg <= 1'b1;
      end else if (bus.out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_data  = out_data_reg;
   assign bus.out_strb  = out_strb_reg;
   assign bus.out_last  = out_last_reg;
   assign bus.out_valid = out_valid_reg;

endmodule
